// File: rtl/irq_prio_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the irq_prio_ctrl block.
package irq_prio_pkg;

    localparam int unsigned NUM_SRC = 8;
    localparam int unsigned ID_W    = 3;
    localparam logic [NUM_SRC-1:0] MASK_RST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [ID_W-1:0] id);
        return NUM_SRC'(1) << id;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8->3 highest-set-bit encoder with an all-zero flag.
module prio_enc8
    import irq_prio_pkg::*;
(
    input  logic [NUM_SRC-1:0] cand_i,
    output logic [ID_W-1:0]    sel_c,
    output logic               zero_c
);

    // Ascending scan so the highest set bit is the last assignment to stick.
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand_i[i]) begin
                sel_c = ID_W'(i);
            end
        end
    end

    assign zero_c = (cand_i == '0);

endmodule

// File: rtl/irq_prio_ctrl.sv
// 8-source priority interrupt controller with mask register and ack/eoi handshake.
// Define IRQ_EDGE_EN for rising-edge request detection; level detection otherwise.
module irq_prio_ctrl
    import irq_prio_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic               ack,
    input  logic               eoi,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] in_service,
    output logic [NUM_SRC-1:0] mask
);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               irq_q, irq_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] det, clr, cand;
    logic [ID_W-1:0]    sel_c;
    logic               cand_z_c;

`ifdef IRQ_EDGE_EN
    logic [NUM_SRC-1:0] irq_in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_in_q <= '0;
        end else begin
            irq_in_q <= irq_in;
        end
    end

    assign det = irq_in & ~irq_in_q;
`else
    assign det = irq_in;
`endif

    assign cand = pending_q & ~mask_q;

    prio_enc8 u_prio_enc8 (
        .cand_i (cand),
        .sel_c  (sel_c),
        .zero_c (cand_z_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        clr          = '0;
        unique case (state_q)
            IDLE: begin
                if (!cand_z_c) begin
                    state_d  = REQ;
                    irq_d    = 1'b1;
                    irq_id_d = sel_c;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d      = SERVICE;
                    irq_d        = 1'b0;
                    clr          = onehot(irq_id_q);
                    in_service_d = onehot(irq_id_q);
                end else if (!cand[irq_id_q]) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end
            end
            SERVICE: begin
                irq_d = 1'b0;
                if (eoi) begin
                    state_d      = IDLE;
                    in_service_d = '0;
                end
            end
            default: begin
                state_d      = IDLE;
                irq_d        = 1'b0;
                in_service_d = '0;
            end
        endcase
    end

    // Clear beats set on the same edge; a held level re-sets on the following edge.
    assign pending_d = (pending_q | det) & ~clr;
    assign mask_d    = mask_wr ? mask_data : mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            mask_q       <= MASK_RST;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq        = irq_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Self-checking bench for irq_prio_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_irq_prio_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_in = '0;
    logic       mask_wr = 1'b0;
    logic [7:0] mask_data = '0;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] in_service;
    logic [7:0] mask;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which source is being presented / serviced (-1 = none).
    int       m_pres, m_serv, m_id;
    bit [7:0] m_pend, m_mask, m_prev_in;

    irq_prio_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .ack        (ack),
        .eoi        (eoi),
        .irq        (irq),
        .irq_id     (irq_id),
        .in_service (in_service),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    function automatic int highest(input bit [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pres = -1; m_serv = -1; m_id = 0;
        m_pend = '0; m_mask = 8'hFF; m_prev_in = '0;
    endtask

    task automatic model_step();
        bit [7:0] det, cand, clr;
`ifdef IRQ_EDGE_EN
        det = irq_in & ~m_prev_in;
`else
        det = irq_in;
`endif
        cand = m_pend & ~m_mask;
        clr  = '0;
        if (m_pres >= 0) begin
            if (ack) begin
                m_serv = m_pres;
                clr[m_pres] = 1'b1;
                m_pres = -1;
            end else if (!cand[m_pres]) begin
                m_pres = -1;
            end
        end else if (m_serv >= 0) begin
            if (eoi) m_serv = -1;
        end else if (cand != 0) begin
            m_pres = highest(cand);
            m_id   = m_pres;
        end
        m_pend    = (m_pend | det) & ~clr;
        if (mask_wr) m_mask = mask_data;
        m_prev_in = irq_in;
    endtask

    function automatic bit [7:0] m_isr();
        return (m_serv >= 0) ? (8'h01 << m_serv) : 8'h00;
    endfunction

    // One clock: model follows the edge, outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic set_idle_inputs();
        irq_in = '0; mask_wr = 1'b0; mask_data = '0; ack = 1'b0; eoi = 1'b0;
    endtask

    task automatic write_mask(input bit [7:0] v);
        mask_wr = 1'b1; mask_data = v;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic test_reset();
        set_idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #22;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (irq_id !== 3'd0) begin n_err++; $display("FAIL reset_id got %0d want 0", irq_id); end
        n_cmp++; if (in_service !== 8'h00) begin n_err++; $display("FAIL reset_isr got %h want 00", in_service); end
        n_cmp++; if (mask !== 8'hFF) begin n_err++; $display("FAIL reset_mask got %h want ff", mask); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency_order();
        write_mask(8'h00);
        n_cmp++; if (mask !== 8'h00) begin n_err++; $display("FAIL s1_mask got %h want 00", mask); end
        irq_in = 8'h24;
        tick();
        irq_in = 8'h00;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL s1_early got %b want 0", irq); end
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd5) begin n_err++; $display("FAIL s1_first got irq=%b id=%0d want irq=1 id=5", irq, irq_id); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_cmp++; if (in_service !== 8'h20 || irq !== 1'b0) begin n_err++; $display("FAIL s1_ack got isr=%h irq=%b want isr=20 irq=0", in_service, irq); end
        tick(); tick();
        n_cmp++; if (irq !== 1'b0 || irq_id !== 3'd5) begin n_err++; $display("FAIL s1_nonest got irq=%b id=%0d want irq=0 id=5", irq, irq_id); end
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        n_cmp++; if (in_service !== 8'h00 || irq !== 1'b0) begin n_err++; $display("FAIL s1_eoi got isr=%h irq=%b want isr=00 irq=0", in_service, irq); end
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd2) begin n_err++; $display("FAIL s1_second got irq=%b id=%0d want irq=1 id=2", irq, irq_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_no_preempt();
        write_mask(8'h80);
        irq_in = 8'h81;
        tick();
        irq_in = 8'h00;
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd0) begin n_err++; $display("FAIL s2_masked7 got irq=%b id=%0d want irq=1 id=0", irq, irq_id); end
        write_mask(8'h00);
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd0) begin n_err++; $display("FAIL s2_frozen got irq=%b id=%0d want irq=1 id=0", irq, irq_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        n_cmp++; if (in_service !== 8'h01) begin n_err++; $display("FAIL s2_isr got %h want 01", in_service); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd7) begin n_err++; $display("FAIL s2_next got irq=%b id=%0d want irq=1 id=7", irq, irq_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_mask_withdraw();
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd3) begin n_err++; $display("FAIL s3_req got irq=%b id=%0d want irq=1 id=3", irq, irq_id); end
        write_mask(8'h08);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL s3_hold got %b want 1", irq); end
        tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL s3_drop got %b want 0", irq); end
        tick();
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL s3_stay got %b want 0", irq); end
        write_mask(8'h00);
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd3) begin n_err++; $display("FAIL s3_kept got irq=%b id=%0d want irq=1 id=3", irq, irq_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_ack_vs_mask();
        irq_in = 8'h10;
        tick();
        irq_in = 8'h00;
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd4) begin n_err++; $display("FAIL s4_req got irq=%b id=%0d want irq=1 id=4", irq, irq_id); end
        ack = 1'b1; mask_wr = 1'b1; mask_data = 8'hFF; eoi = 1'b1;
        tick();
        ack = 1'b0; mask_wr = 1'b0; eoi = 1'b0;
        n_cmp++; if (in_service !== 8'h10 || irq !== 1'b0 || mask !== 8'hFF) begin n_err++; $display("FAIL s4_ackwins got isr=%h irq=%b mask=%h want isr=10 irq=0 mask=ff", in_service, irq, mask); end
        tick();
        n_cmp++; if (in_service !== 8'h10) begin n_err++; $display("FAIL s4_service got %h want 10", in_service); end
        eoi = 1'b1; tick(); eoi = 1'b0;
        write_mask(8'h00);
    endtask

    task automatic test_level_vs_edge();
        irq_in = 8'h40;
        tick(); tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd6) begin n_err++; $display("FAIL s5_req got irq=%b id=%0d want irq=1 id=6", irq, irq_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        tick();
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
`ifdef IRQ_EDGE_EN
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL s5_edge_held got %b want 0", irq); end
        irq_in = 8'h00; tick();
        irq_in = 8'h40; tick();
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd6) begin n_err++; $display("FAIL s5_edge_retrig got irq=%b id=%0d want irq=1 id=6", irq, irq_id); end
`else
        n_cmp++; if (irq !== 1'b1 || irq_id !== 3'd6) begin n_err++; $display("FAIL s5_level_repres got irq=%b id=%0d want irq=1 id=6", irq, irq_id); end
`endif
        irq_in = 8'h00; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        n_cmp++; if (irq !== 1'b0 || in_service !== 8'h00) begin n_err++; $display("FAIL s5_clean got irq=%b isr=%h want irq=0 isr=00", irq, in_service); end
    endtask

    task automatic test_async_reset();
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        n_cmp++; if (in_service !== 8'h02) begin n_err++; $display("FAIL s6_service got %h want 02", in_service); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (irq !== 1'b0 || irq_id !== 3'd0 || in_service !== 8'h00 || mask !== 8'hFF) begin
            n_err++; $display("FAIL s6_async got irq=%b id=%0d isr=%h mask=%h want 0 0 00 ff", irq, irq_id, in_service, mask);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            irq_in    = 8'($urandom & $urandom & $urandom);
            mask_wr   = ($urandom_range(0, 15) == 0);
            mask_data = 8'($urandom);
            ack       = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++; if (irq !== (m_pres >= 0)) begin n_err++; $display("FAIL rnd_irq c=%0d got %b want %b", c, irq, (m_pres >= 0)); end
            n_cmp++; if (in_service !== m_isr()) begin n_err++; $display("FAIL rnd_isr c=%0d got %h want %h", c, in_service, m_isr()); end
            n_cmp++; if (mask !== m_mask) begin n_err++; $display("FAIL rnd_mask c=%0d got %h want %h", c, mask, m_mask); end
            if (m_pres >= 0 || m_serv >= 0) begin
                n_cmp++; if (irq_id !== 3'(m_id)) begin n_err++; $display("FAIL rnd_id c=%0d got %0d want %0d", c, irq_id, m_id); end
            end
        end
        set_idle_inputs();
    endtask

    initial begin
        test_reset();
        test_latency_order();
        test_no_preempt();
        test_mask_withdraw();
        test_ack_vs_mask();
        test_level_vs_edge();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
